unidade_controle_jogada: RTL and testbench

//  Control unit (Moore FSM) for the counter/compare datapath (zera, carrega, conta in; igual, fim out).

---
 rtl/unidade_controle_jogada.sv | 161 ++++++++++++++++
 tb/tb_unidade_controle_jogada.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogada.sv
// rtl/unidade_controle_jogada.sv - Moore control unit sequencing one round of the counter/compare game
//
// Optional feature: define TIMEOUT_EN to add an ESPERA watchdog that forces a miss
// after TIMEOUT_CYCLES cycles without a player move.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   synchronous active-low reset
//   iniciar    in   start/restart request (level)
//   jogada     in   player move button (only its rising edge is used)
//   igual      in   datapath compare result
//   fim        in   datapath counter terminal count
//   zera       out  clear datapath counter and register
//   carrega    out  load switches into datapath register
//   conta      out  increment datapath counter
//   pronto     out  round finished
//   acertou    out  round ended with all matches
//   errou      out  round ended with a mismatch or timeout
//   timeout    out  miss was caused by timeout
//   db_estado  out  current state code for the debug display
`timescale 1ns/1ps

module unidade_controle_jogada #(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       carrega,
  output logic       conta,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h4,
    COMPARA  = 4'h5,
    PROXIMO  = 4'h6,
    ACERTOU  = 4'hA,
    ERROU    = 4'hE
  } estado_t;

  estado_t estado;
  estado_t proximo;
  logic    jogada_d;
  logic    jogada_ev;
  logic    expirou;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= INICIAL;
      jogada_d <= 1'b0;
    end else begin
      estado   <= proximo;
      jogada_d <= jogada;
    end
  end

  // A held button yields a single event; events outside ESPERA are simply ignored.
  assign jogada_ev = jogada & ~jogada_d;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          por_timeout;

  // Held at zero outside ESPERA, so every entry into ESPERA starts from zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer <= '0;
    end else if (estado != ESPERA) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign expirou = (estado == ESPERA) && (timer == TMAX);

  // Remembers that ERROU was reached from ESPERA (only a timeout does that);
  // dropped as soon as ERROU is left.
  always_ff @(posedge clock) begin
    if (!reset) begin
      por_timeout <= 1'b0;
    end else if (estado == ESPERA) begin
      por_timeout <= (proximo == ERROU);
    end else begin
      por_timeout <= por_timeout && (proximo == ERROU);
    end
  end

  assign timeout = (estado == ERROU) && por_timeout;
`else
  logic cfg_unused;
  assign cfg_unused = (TIMEOUT_CYCLES >= 2);
  assign expirou    = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:  proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:  proximo = ESPERA;
      ESPERA: begin
        // A move on the expiry cycle takes priority over the timeout.
        if (jogada_ev)    proximo = REGISTRA;
        else if (expirou) proximo = ERROU;
        else              proximo = ESPERA;
      end
      REGISTRA: proximo = COMPARA;
      COMPARA: begin
        if (!igual)   proximo = ERROU;
        else if (fim) proximo = ACERTOU;
        else          proximo = PROXIMO;
      end
      PROXIMO:  proximo = ESPERA;
      ACERTOU:  proximo = iniciar ? PREPARA : ACERTOU;
      ERROU:    proximo = iniciar ? PREPARA : ERROU;
      default:  proximo = INICIAL;
    endcase
  end

  always_comb begin
    zera    = 1'b0;
    carrega = 1'b0;
    conta   = 1'b0;
    pronto  = 1'b0;
    acertou = 1'b0;
    errou   = 1'b0;
    case (estado)
      PREPARA:  zera    = 1'b1;
      REGISTRA: carrega = 1'b1;
      PROXIMO:  conta   = 1'b1;
      ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// tb/tb_unidade_controle_jogada.sv - directed self-checking bench for unidade_controle_jogada
`timescale 1ns/1ps

module tb_unidade_controle_jogada;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b0;
  logic       fim = 1'b0;
  logic       zera, carrega, conta, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int n_assert = 0;
  int n_fail   = 0;
  int conta_cnt;

  // Output vector order: {zera, carrega, conta, pronto, acertou, errou, timeout}
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_ZERA  = 7'b1000000;
  localparam logic [6:0] O_CARR  = 7'b0100000;
  localparam logic [6:0] O_CONTA = 7'b0010000;
  localparam logic [6:0] O_HIT   = 7'b0001100;
  localparam logic [6:0] O_MISS  = 7'b0001010;
  localparam logic [6:0] O_TOUT  = 7'b0001011;

  unidade_controle_jogada #(.TIMEOUT_CYCLES(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fim       (fim),
    .zera      (zera),
    .carrega   (carrega),
    .conta     (conta),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [3:0] exp_st, input logic [6:0] exp_out);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {db_estado, zera, carrega, conta, pronto, acertou, errou, timeout};
    exp = {exp_st, exp_out};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed st=%h out=%b, expected st=%h out=%b",
             tag, obs[10:7], obs[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_round(input string tag);
    iniciar = 1'b1;
    step();
    check({tag, "_prepara"}, 4'h1, O_ZERA);
    iniciar = 1'b0;
    step();
    check({tag, "_espera"}, 4'h2, O_NONE);
  endtask

  // One move from ESPERA: rising edge, register, compare, then outcome.
  task automatic move(input string tag, input logic ig, input logic fm);
    igual  = ig;
    fim    = fm;
    jogada = 1'b1;
    step();
    check({tag, "_registra"}, 4'h4, O_CARR);
    jogada = 1'b0;
    step();
    check({tag, "_compara"}, 4'h5, O_NONE);
    step();
    if (!ig) begin
      check({tag, "_errou"}, 4'hE, O_MISS);
    end else if (fm) begin
      check({tag, "_acertou"}, 4'hA, O_HIT);
    end else begin
      if (conta) conta_cnt++;
      check({tag, "_proximo"}, 4'h6, O_CONTA);
      step();
      check({tag, "_volta"}, 4'h2, O_NONE);
    end
  endtask

  initial begin
    // 1: reset and start
    step();
    step();
    check("reset", 4'h0, O_NONE);
    reset = 1'b1;
    step();
    check("idle", 4'h0, O_NONE);
    start_round("t1");

    // 2: held jogada yields one event only
    igual  = 1'b1;
    fim    = 1'b0;
    jogada = 1'b1;
    step();
    check("held_registra", 4'h4, O_CARR);
    step();
    check("held_compara", 4'h5, O_NONE);
    step();
    check("held_proximo", 4'h6, O_CONTA);
    step();
    check("held_espera", 4'h2, O_NONE);
    step();
    check("held_no_second", 4'h2, O_NONE);
    jogada = 1'b0;
    step();
    check("held_release", 4'h2, O_NONE);

    // iniciar is ignored mid-round
    iniciar = 1'b1;
    step();
    check("iniciar_ignored", 4'h2, O_NONE);
    iniciar = 1'b0;

    // 3: full round of 16 matches
    reset = 1'b0;
    step();
    check("reset_mid", 4'h0, O_NONE);
    reset = 1'b1;
    start_round("t3");
    conta_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      move($sformatf("hit%0d", i), 1'b1, (i == 15));
    end
    check_int("conta_pulses", conta_cnt, 15);
    step();
    check("acertou_hold", 4'hA, O_HIT);

    // 4: miss on third move, then restart
    start_round("t4");
    move("m0", 1'b1, 1'b0);
    move("m1", 1'b1, 1'b0);
    move("m2", 1'b0, 1'b0);
    step();
    check("errou_hold", 4'hE, O_MISS);
    start_round("t4r");

    // 5: reset while in REGISTRA
    igual  = 1'b1;
    jogada = 1'b1;
    step();
    check("t5_registra", 4'h4, O_CARR);
    reset  = 1'b0;
    jogada = 1'b0;
    step();
    check("t5_reset", 4'h0, O_NONE);
    reset = 1'b1;
    step();
    check("t5_after", 4'h0, O_NONE);

    // 6: timeout behaviour
    start_round("t6");
`ifdef TIMEOUT_EN
    repeat (7) step();
    check("t6_before_expiry", 4'h2, O_NONE);
    step();
    check("t6_timeout", 4'hE, O_TOUT);
    start_round("t6r");
`else
    repeat (100) step();
    check("t6_no_timeout", 4'h2, O_NONE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
